pipeline_trace_unit: RTL
========================

# pipeline_trace_unit

Synthesizable writeback tracer that sits beside the pipelined RISC-V core and taps its writeback stage. It records register writebacks and performance counts in hardware, replacing simulation-only register dumps and `$monitor` tracing. Capture is armed by software or a bench and can wait for a PC trigger. Captured entries drain through a parametrised FIFO over a valid/ready port.

## Interface
- XLEN, 32, data/PC width
- DEPTH, 16, trace FIFO entries; power of two, ≥2
- CNT_W, 32, width of every counter
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- arm  in  1  pulse; starts a capture session
- trig_en  in  1  1 = wait for PC match after arm; 0 = start immediately
- trig_pc  in  XLEN  trigger PC
- stop  in  1  pulse; ends session
- wb_valid  in  1  instruction retiring in writeback this cycle
- wb_pc  in  XLEN  PC of retiring instruction
- wb_we  in  1  register write enable
- wb_rd  in  5  destination register
- wb_data  in  XLEN  writeback data
- stall  in  1  core stall this cycle
- flush  in  1  core flush this cycle
- tr_valid  out  1  trace entry available
- tr_ready  in  1  consumer accepts entry
- tr_pc / tr_rd / tr_data  out  XLEN / 5 / XLEN  head entry
- state  out  2  FSM state
- cyc_cnt, ret_cnt, stall_cnt, flush_cnt, drop_cnt  out  CNT_W each  counters
- overflow  out  1  sticky; an entry was dropped
- dbg_addr  in  5  shadow-register read address
- dbg_data  out  XLEN  shadow-register read data

## Operation
- FSM states: IDLE=0, ARMED=1, RUN=2, HALT=3.
  - IDLE/HALT + arm: clear all counters, FIFO and overflow. Go to RUN if trig_en=0, else to ARMED.
  - ARMED + wb_valid with wb_pc==trig_pc: go to RUN. That retiring instruction is itself counted and captured.
  - ARMED/RUN + stop: go to HALT. stop has priority over the trigger in the same cycle.
  - arm while in ARMED/RUN is ignored. stop in IDLE/HALT is ignored.
- Counting in RUN:
  - cyc_cnt +1 every cycle.
  - ret_cnt +1 on wb_valid.
  - stall_cnt +1 on stall.
  - flush_cnt +1 on flush.
- Capture in RUN: when wb_valid && wb_we && wb_rd!=0, push {wb_pc, wb_rd, wb_data}.
- FIFO full:
  - A push with no pop in the same cycle is dropped; drop_cnt +1 and overflow set.
  - A simultaneous push and pop while full is accepted; occupancy is unchanged.
- All counters saturate at all-ones and never wrap.
- Drain: an entry is popped when tr_valid && tr_ready. Draining works in every state. HALT preserves the FIFO and counters until the next arm.
- Reset (rst=0 at edge), including mid-session:
  - state=IDLE.
  - FIFO emptied; tr_valid=0; tr_pc, tr_rd, tr_data = 0.
  - All counters 0; overflow=0; dbg_data=0.

## Timing
- All outputs are registered, except dbg_data (see Configuration).
- Capture latency: a qualifying writeback in cycle N gives tr_valid=1 in cycle N+1 if the FIFO was empty.
- Counters reflect cycle-N events from cycle N+1.
- state updates the cycle after arm, stop, or the trigger.
- tr_* fields stay stable while tr_valid && !tr_ready. The next entry appears the cycle after a pop.
- FIFO read and write pointers are log2(DEPTH)+1 bits wide; full/empty come from the MSB comparison. Pointer wrap is exercised at DEPTH pushes.

## Configuration
- TRACE_SHADOW_EN defined:
  - A 32×XLEN shadow register file is updated on every wb_valid && wb_we && wb_rd!=0, in any state, mirroring architectural state.
  - dbg_data = shadow[dbg_addr], combinational.
  - x0 reads 0.
  - The shadow file is cleared to 0 on reset.
- TRACE_SHADOW_EN undefined: no shadow storage; dbg_data is tied to 0 and dbg_addr is ignored.

## Structure
- Package pipeline_trace_pkg holds:
  - the state encoding constants,
  - the trace-entry field widths and the packed entry type (pc, rd, data),
  - the counter-saturation helper.
- Sub-module trace_fifo: parametrised synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty. The FSM, counters and shadow file live in the top level.

## Test plan
- Reset, then arm with trig_en=0, then 3 writebacks (x1=7, x2=8, x3=15) with tr_ready=1:
  - three entries come out in order, each 1 cycle after its writeback;
  - ret_cnt=3, state=RUN.
- trig_en=1, trig_pc=0x10, arm, then retire PCs 0x0, 0x4, 0x10, 0x14:
  - only the 0x10 and 0x14 entries are captured;
  - ret_cnt=2.
- DEPTH=16, tr_ready=0, 20 qualifying writebacks:
  - 16 entries held, drop_cnt=4, overflow=1;
  - draining then yields the first 16 in order, with pointer wrap.
- Writeback to x0 with wb_we=1 during RUN: ret_cnt increments, no FIFO entry is created, shadow x0 reads 0.
- stop and trigger match in the same cycle while ARMED: state goes to HALT, nothing is captured. A later arm clears all counters.
- Assert rst=0 mid-RUN with 5 entries queued:
  - the next cycle shows state=IDLE, tr_valid=0, all counters 0;
  - with TRACE_SHADOW_EN, dbg_data for x5 reads 0.

Source files
------------

// File: rtl/pipeline_trace_pkg.sv
// pipeline_trace_pkg: state encoding, trace entry layout and counter saturation helper
package pipeline_trace_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;
  localparam int PC_W = 32;
  localparam int RD_W = 5;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } entry_t;
  function automatic logic bump(input logic ev, input logic at_max);
    return ev && !at_max;
  endfunction
endpackage

// File: rtl/pipeline_trace_unit_trace_fifo.sv
// trace_fifo: synchronous FIFO with extra-MSB pointers, zero output when empty
module trace_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop) rp <= rp + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/pipeline_trace_unit.sv
// pipeline_trace_unit: writeback tracer with counters, trace FIFO and optional TRACE_SHADOW_EN shadow regfile
module pipeline_trace_unit
  import pipeline_trace_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             trig_en,
  input  logic [XLEN-1:0]  trig_pc,
  input  logic             stop,
  input  logic             wb_valid,
  input  logic [XLEN-1:0]  wb_pc,
  input  logic             wb_we,
  input  logic [RD_W-1:0]  wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             stall,
  input  logic             flush,
  output logic             tr_valid,
  input  logic             tr_ready,
  output logic [XLEN-1:0]  tr_pc,
  output logic [RD_W-1:0]  tr_rd,
  output logic [XLEN-1:0]  tr_data,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow,
  input  logic [RD_W-1:0]  dbg_addr,
  output logic [XLEN-1:0]  dbg_data
);
  localparam int EW = 2*XLEN + RD_W;
  state_t st, nxt;
  logic idle_like, busy, hit, live, clr, cap, pop, full, empty, drop;
  logic [EW-1:0] dout;
  assign idle_like = st == IDLE || st == HALT;
  assign busy = st == ARMED || st == RUN;
  assign hit = wb_valid && wb_pc == trig_pc;
  assign live = st == RUN || (st == ARMED && hit && !stop);
  assign clr = idle_like && arm;
  assign cap = live && wb_valid && wb_we && wb_rd != '0;
  assign pop = tr_valid && tr_ready;
  assign drop = cap && full && !pop;
  always_ff @(posedge clk) begin
    st <= !rst ? IDLE : nxt;
  end
  always_comb begin
    nxt = st;
    if (clr) nxt = trig_en ? ARMED : RUN;
    else if (busy && stop) nxt = HALT;
    else if (st == ARMED && hit) nxt = RUN;
  end
  assign state = st;
  trace_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .clr(clr), .push(cap), .pop(pop),
    .din({wb_pc, wb_rd, wb_data}), .dout(dout), .full(full), .empty(empty)
  );
  assign tr_valid = !empty;
  assign {tr_pc, tr_rd, tr_data} = dout;
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt + CNT_W'(bump(live, &cyc_cnt));
      ret_cnt <= ret_cnt + CNT_W'(bump(live && wb_valid, &ret_cnt));
      stall_cnt <= stall_cnt + CNT_W'(bump(live && stall, &stall_cnt));
      flush_cnt <= flush_cnt + CNT_W'(bump(live && flush, &flush_cnt));
      drop_cnt <= drop_cnt + CNT_W'(bump(drop, &drop_cnt));
      overflow <= overflow || drop;
    end
  end
`ifdef TRACE_SHADOW_EN
  logic [XLEN-1:0] shadow [32];
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) shadow[i] <= '0;
    end else if (wb_valid && wb_we && wb_rd != '0) begin
      shadow[wb_rd] <= wb_data;
    end
  end
  assign dbg_data = shadow[dbg_addr];
`else
  logic unused_dbg;
  assign unused_dbg = ^dbg_addr;
  assign dbg_data = '0;
`endif
endmodule
